// File: rtl/key_rate_pkg.sv
// key_rate_pkg: shared types and helpers for the key-driven blink-rate selector.
package key_rate_pkg;
  localparam int RATE_W = 2;
  typedef enum logic [1:0] {UP, CHK_DN, DOWN, CHK_UP} key_state_e;
  function automatic logic [31:0] rate_to_cnt(input logic [RATE_W-1:0] idx, input logic [31:0] clk_hz);
    return clk_hz >> idx;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop single-bit synchronizer with selectable reset level.
module sync_2ff #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic s1_q, s2_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end
  assign q_o = s2_q;
endmodule

// File: rtl/key_rate_select.sv
// key_rate_select: debounced push-button stepping a 2-bit blink-rate index.
// Optional long-press return to the slowest rate: define KEY_RATE_LONG_PRESS_EN.
module key_rate_select
  import key_rate_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50000000,
  parameter int unsigned DEBOUNCE_MS    = 20,
  parameter int unsigned KEY_ACTIVE_LOW = 1,
  parameter int unsigned LONG_MS        = 1000
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              key_in,
  output logic              key_level,
  output logic              key_press,
  output logic              key_release,
  output logic [RATE_W-1:0] rate_idx,
  output logic [31:0]       dly_cnt,
  output logic [31:0]       half_dly_cnt,
  output logic              long_press
);
  localparam logic [31:0] CLK_HZ32 = 32'(CLK_HZ);
  localparam logic [31:0] DB_CNT   = (CLK_HZ32 / 32'd1000) * 32'(DEBOUNCE_MS);
  localparam logic [31:0] LCNT     = (CLK_HZ32 / 32'd1000) * 32'(LONG_MS);
  if (DB_CNT < 32'd1 || LCNT < 32'd1) begin : g_bad_cfg
    $error("key_rate_select: debounce and long-press counts must be at least 1");
  end
  logic              key_sync, k;
  key_state_e        state_q, state_d;
  logic [31:0]       cnt_q, cnt_d, dly_q, dly_d;
  logic              press_q, press_d, release_q, release_d, long_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  sync_2ff #(.RST_VAL(KEY_ACTIVE_LOW != 0)) u_sync (
    .clk (sys_clk),
    .rst (sys_rst),
    .d_i (key_in),
    .q_o (key_sync)
  );
  assign k = (KEY_ACTIVE_LOW != 0) ? ~key_sync : key_sync;
`ifdef KEY_RATE_LONG_PRESS_EN
  logic [31:0] hold_q, hold_d;
  logic        long_q;
  // Hold count saturates at LCNT so the pulse fires only once per press.
  always_comb begin
    hold_d = (state_q != DOWN) ? '0 : (hold_q != LCNT) ? hold_q + 32'd1 : hold_q;
    long_d = (state_q == DOWN) && (hold_q == LCNT - 32'd1);
  end
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end
  assign long_press = long_q;
`else
  assign long_d     = 1'b0;
  assign long_press = 1'b0;
`endif
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    rate_d    = rate_q;
    dly_d     = dly_q;
    case (state_q)
      UP:   state_d = k ? CHK_DN : UP;
      DOWN: state_d = k ? DOWN : CHK_UP;
      CHK_DN: begin
        if (!k) state_d = UP;
        else if (cnt_q == DB_CNT - 32'd1) begin
          state_d = DOWN;
          press_d = 1'b1;
          rate_d  = rate_q + 2'd1;
          dly_d   = rate_to_cnt(rate_q + 2'd1, CLK_HZ32);
        end else cnt_d = cnt_q + 32'd1;
      end
      default: begin
        if (k) state_d = DOWN;
        else if (cnt_q == DB_CNT - 32'd1) begin
          state_d   = UP;
          release_d = 1'b1;
        end else cnt_d = cnt_q + 32'd1;
      end
    endcase
    if (long_d) begin
      rate_d = '0;
      dly_d  = CLK_HZ32;
    end
  end
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= UP;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      rate_q    <= '0;
      dly_q     <= CLK_HZ32;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      rate_q    <= rate_d;
      dly_q     <= dly_d;
    end
  end
  assign key_level    = (state_q == DOWN) || (state_q == CHK_UP);
  assign key_press    = press_q;
  assign key_release  = release_q;
  assign rate_idx     = rate_q;
  assign dly_cnt      = dly_q;
  assign half_dly_cnt = dly_q >> 1;
endmodule

// File: tb/tb_key_rate_select.sv
// tb_key_rate_select: directed checks of debounce timing, rate stepping and reset.
module tb_key_rate_select;
  logic        clk = 1'b0, rst = 1'b1, key_in = 1'b1;
  logic        key_level, key_press, key_release, long_press;
  logic [1:0]  rate_idx;
  logic [31:0] dly_cnt, half_dly_cnt;
  int          checks = 0, failures = 0;
  int          n_press = 0, n_release = 0, n_long = 0, n_both = 0;
  int          exp_press = 0, exp_release = 0;
  logic [1:0]  exp_rate = 2'd0;

  key_rate_select #(.CLK_HZ(1000), .DEBOUNCE_MS(4), .KEY_ACTIVE_LOW(1), .LONG_MS(10)) dut (
    .sys_clk(clk), .sys_rst(rst), .key_in(key_in), .key_level(key_level),
    .key_press(key_press), .key_release(key_release), .rate_idx(rate_idx),
    .dly_cnt(dly_cnt), .half_dly_cnt(half_dly_cnt), .long_press(long_press)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (key_press) n_press++;
    if (key_release) n_release++;
    if (long_press) n_long++;
    if (key_press && key_release) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] period(input logic [1:0] r);
    case (r)
      2'd0: return 32'd1000;
      2'd1: return 32'd500;
      2'd2: return 32'd250;
      default: return 32'd125;
    endcase
  endfunction

  task automatic check_rate(input string tag);
    chk({tag, "_rate"}, 32'(rate_idx), 32'(exp_rate));
    chk({tag, "_dly"}, dly_cnt, period(exp_rate));
    chk({tag, "_half"}, half_dly_cnt, period(exp_rate) >> 1);
  endtask

  task automatic press_key();
    key_in = 1'b0;
    exp_rate = exp_rate + 2'd1;
    exp_press++;
    repeat (6) @(negedge clk);
    chk("press_early", 32'(key_press), 0);
    @(negedge clk);
    chk("press_pulse", 32'(key_press), 1);
    chk("press_level", 32'(key_level), 1);
    check_rate("press");
    @(negedge clk);
    chk("press_width", 32'(key_press), 0);
  endtask

  task automatic release_key();
    key_in = 1'b1;
    exp_release++;
    repeat (6) @(negedge clk);
    chk("release_early", 32'(key_release), 0);
    @(negedge clk);
    chk("release_pulse", 32'(key_release), 1);
    chk("release_level", 32'(key_level), 0);
    check_rate("release");
    @(negedge clk);
    chk("release_width", 32'(key_release), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_level", 32'(key_level), 0);
    chk("rst_press", 32'(key_press), 0);
    chk("rst_release", 32'(key_release), 0);
    chk("rst_long", 32'(long_press), 0);
    check_rate("rst");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    press_key();
    release_key();
    key_in = 1'b0;
    repeat (2) @(negedge clk);
    key_in = 1'b1;
    @(negedge clk);
    press_key();
    repeat (3) @(negedge clk);
    chk("bounce_press_count", 32'(n_press), 32'(exp_press));
    chk("bounce_no_release", 32'(n_release), 32'(exp_release));
    release_key();
    for (int i = 0; i < 4; i++) begin
      press_key();
      repeat (2) @(negedge clk);
      release_key();
      repeat (2) @(negedge clk);
    end
`ifdef KEY_RATE_LONG_PRESS_EN
    press_key();
    repeat (8) @(negedge clk);
    chk("long_early", 32'(long_press), 0);
    @(negedge clk);
    exp_rate = 2'd0;
    chk("long_pulse", 32'(long_press), 1);
    check_rate("long");
    @(negedge clk);
    chk("long_width", 32'(long_press), 0);
    repeat (4) @(negedge clk);
    chk("long_once", 32'(n_long), 1);
    release_key();
`else
    press_key();
    repeat (14) @(negedge clk);
    chk("long_off_level", 32'(long_press), 0);
    chk("long_off_count", 32'(n_long), 0);
    release_key();
`endif
    press_key();
    repeat (2) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    exp_rate = 2'd0;
    chk("arst_level", 32'(key_level), 0);
    chk("arst_press", 32'(key_press), 0);
    check_rate("arst");
    @(negedge clk);
    rst = 1'b0;
    press_key();
    release_key();
    repeat (3) @(negedge clk);
    chk("total_press", 32'(n_press), 32'(exp_press));
    chk("total_release", 32'(n_release), 32'(exp_release));
    chk("never_both", 32'(n_both), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
